result_drain_arbiter: RTL and testbench
=======================================

# result_drain_arbiter

Round-robin read scheduler that drains the three per-port result queues of the switch and merges their bytes onto one valid/ready stream toward the host-facing readout logic. For each queue it issues single-cycle read strobes, captures the 1-cycle-latency read data, and tags each byte with its source port. It also keeps per-port drained-word counters for software status reads.

## Interface
- DATA_W, 8, width of queue data and output data
- CNT_W, 14, width of per-port drained-word counters
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  when low, no new grant is issued; a transfer already in flight completes
- empty  in  3  bit i high = queue i has no data; sampled only in IDLE
- q0, q1, q2  in  DATA_W  queue read data, valid the cycle after that queue's rd strobe
- rd  out  3  one-hot read strobe, high for exactly one cycle per grant
- out_data  out  DATA_W  captured byte
- out_port  out  2  source queue of out_data (0, 1 or 2)
- out_valid  out  1  out_data/out_port valid
- out_ready  in  1  consumer accepts the word when out_valid && out_ready at a rising edge
- cnt0, cnt1, cnt2  out  CNT_W  words delivered per port, wrap modulo 2^CNT_W
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, READ, WAIT, HOLD.
- IDLE: when enable=1 and any empty bit is 0, register grant g = first non-empty port searching (last+1), (last+2), last, all mod 3; go to READ. Otherwise stay in IDLE.
- READ: rd[g]=1, other rd bits 0; go to WAIT unconditionally.
- WAIT: out_data <= q[g], out_port <= g, out_valid <= 1; go to HOLD.
- HOLD: out_valid held high and out_data/out_port stable until out_ready=1. On acceptance: out_valid <= 0, last <= g, cnt[g] <= cnt[g]+1, go to IDLE.
- Reset values: state=IDLE, last=2 so port 0 has first priority, rd=0, out_valid=0, out_data=0, out_port=0, cnt0..cnt2=0, busy=0.
- rd is decoded from state and grant only and carries no other term. No strobe is issued outside READ.
- Fairness: with all three queues continuously non-empty, grants go 0,1,2,0,… A port cannot be granted twice while another port is requesting.
- enable dropping during READ, WAIT or HOLD does not abort the transfer. It only blocks the next IDLE decision.
- Changes to empty outside IDLE are ignored. The queue owner guarantees that a port reporting non-empty in IDLE still holds data at READ.
- Counter overflow: cnt wraps from 2^CNT_W−1 to 0 silently.
- Reset asserted mid-transfer: all state clears immediately and asynchronously, and rd drops at once. A byte already strobed out of a queue but not accepted is lost. This loss is accepted behaviour.

## Timing
- Grant decision in IDLE at edge N. rd high during cycle N+1 (READ). q sampled at edge N+2 (WAIT). out_valid high from edge N+2.
- Minimum latency from a non-empty request seen in IDLE to out_valid: 2 cycles.
- Minimum period per word with out_ready tied high: 4 cycles (IDLE, READ, WAIT, HOLD). Peak throughput is therefore 1 word / 4 clk.
- out_valid never falls without acceptance except on reset. out_data and out_port never change while out_valid=1.
- cnt[g] updates on the same edge that the word is accepted.
- busy is combinational from state, with zero latency.

## Test plan
- Reset: assert reset mid-HOLD with out_valid=1 → rd=0, out_valid=0, cnt0..2=0, busy=0 immediately, without waiting for a clock edge.
- Single port: only queue 1 non-empty, q1=0x2A, out_ready=1 → rd=3'b010 for exactly 1 cycle, out_data=0x2A, out_port=1 two cycles after the grant, cnt1=1.
- Round robin: all queues non-empty for 6 words, out_ready=1 → out_port sequence 0,1,2,0,1,2, one word every 4 cycles, each cnt=2.
- Backpressure: out_ready=0 for 10 cycles during HOLD → out_valid, out_data and out_port stable, no further rd pulse. Raising out_ready → single acceptance and return to IDLE.
- enable: drop enable during READ → current word is still delivered, then no rd while enable=0 even with queues non-empty. Re-enable → arbitration resumes at (last+1).
- Counter wrap: preload scenario with CNT_W=4 and 17 words from port 2 → cnt2 reads 1.

Source files
------------

// File: rtl/result_drain_arbiter.sv
// Round-robin drain of three result queues onto one valid/ready byte stream,
// tagging each byte with its source port and counting words delivered per port.
module result_drain_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        empty,
    input  logic [DATA_W-1:0] q0,
    input  logic [DATA_W-1:0] q1,
    input  logic [DATA_W-1:0] q2,
    output logic [2:0]        rd,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_port,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, HOLD} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        grant;
    logic [1:0]        last;
    logic              grant_en;
    logic              accept;
    logic [DATA_W-1:0] q_sel;

    function automatic logic [1:0] succ(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Search order last+1, last+2, last: the previous winner goes to the back.
    function automatic logic [1:0] rr_pick(input logic [1:0] from, input logic [2:0] emp);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = succ(from);
        c2 = succ(c1);
        if (!emp[c1])
            return c1;
        else if (!emp[c2])
            return c2;
        return from;
    endfunction

    assign grant_en = (state == IDLE) && enable && (empty != 3'b111);
    assign accept   = (state == HOLD) && out_ready;

    always_comb begin
        q_sel = q0;
        case (grant)
            2'd1:    q_sel = q1;
            2'd2:    q_sel = q2;
            default: q_sel = q0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        rd        = 3'b000;
        busy      = (state != IDLE);
        case (state)
            IDLE: if (grant_en) state_nxt = READ;
            READ: begin
                rd[grant] = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // last resets to 2 so that port 0 wins the first arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant     <= 2'd0;
            last      <= 2'd2;
            out_data  <= '0;
            out_port  <= 2'd0;
            out_valid <= 1'b0;
            cnt0      <= '0;
            cnt1      <= '0;
            cnt2      <= '0;
        end else begin
            if (grant_en)
                grant <= rr_pick(last, empty);
            if (state == WAIT) begin
                out_data  <= q_sel;
                out_port  <= grant;
                out_valid <= 1'b1;
            end
            if (accept) begin
                out_valid <= 1'b0;
                last      <= grant;
                case (grant)
                    2'd0:    cnt0 <= cnt0 + 1'b1;
                    2'd1:    cnt1 <= cnt1 + 1'b1;
                    default: cnt2 <= cnt2 + 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_result_drain_arbiter.sv
// Bench for result_drain_arbiter: queue model feeding the DUT, round-robin
// reference with scoreboard, plus directed timing, backpressure and reset cases.
`timescale 1ns/1ps
module tb_result_drain_arbiter;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [2:0]    empty;
    logic [DW-1:0] q0, q1, q2;
    logic [2:0]    rd;
    logic [DW-1:0] out_data;
    logic [1:0]    out_port;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] cnt0, cnt1, cnt2;
    logic          busy;

    result_drain_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .empty(empty),
        .q0(q0), .q1(q1), .q2(q2), .rd(rd),
        .out_data(out_data), .out_port(out_port), .out_valid(out_valid),
        .out_ready(out_ready), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue model: the three per-port result queues owned by the switch.
    logic [DW-1:0] f0[$];
    logic [DW-1:0] f1[$];
    logic [DW-1:0] f2[$];

    function automatic int fsize(input int i);
        case (i)
            0:       return f0.size();
            1:       return f1.size();
            default: return f2.size();
        endcase
    endfunction

    function automatic logic [DW-1:0] fhead(input int i);
        if (fsize(i) == 0) return '0;
        case (i)
            0:       return f0[0];
            1:       return f1[0];
            default: return f2[0];
        endcase
    endfunction

    task automatic fpush(input int i, input logic [DW-1:0] v);
        case (i)
            0:       f0.push_back(v);
            1:       f1.push_back(v);
            default: f2.push_back(v);
        endcase
    endtask

    task automatic fpop(input int i, output logic [DW-1:0] v);
        case (i)
            0:       v = f0.pop_front();
            1:       v = f1.pop_front();
            default: v = f2.pop_front();
        endcase
    endtask

    // Reference: first non-empty port after the previous winner, winner last.
    function automatic int rr(input int from, input logic [2:0] emp);
        for (int k = 1; k <= 3; k++)
            if (!emp[(from + k) % 3]) return (from + k) % 3;
        return from;
    endfunction

    logic [DW+1:0] sb[$];
    int            log_port[$];
    int            log_cyc[$];
    int            mlast = 2;
    int            mcnt[3] = '{0, 0, 0};

    logic          p_idle = 1'b0;
    logic          p_en = 1'b0;
    logic [2:0]    p_empty = 3'b111;
    logic          p_valid = 1'b0;
    logic          p_acc = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic [1:0]    p_port = '0;

    // Monitor and queue responder, run on the falling edge.
    always @(negedge clk) begin
        int g;
        logic acc;
        logic [DW+1:0] e;
        logic [DW-1:0] v;
        if (reset) begin
            sb.delete();
            mlast = 2;
            mcnt = '{0, 0, 0};
            p_valid = 1'b0;
            p_acc = 1'b0;
            chk("reset_rd", rd, 0);
            chk("reset_valid", out_valid, 0);
        end else begin
            chk("cnt0", cnt0, mcnt[0]);
            chk("cnt1", cnt1, mcnt[1]);
            chk("cnt2", cnt2, mcnt[2]);
            if (p_idle && p_en && p_empty != 3'b111) begin
                g = rr(mlast, p_empty);
                chk("grant_rd", rd, 1 << g);
                sb.push_back({g[1:0], fhead(g)});
            end else begin
                chk("idle_rd", rd, 0);
            end
            if (p_valid && !p_acc) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, p_data);
                chk("hold_port", out_port, p_port);
            end
            acc = out_valid && out_ready;
            if (acc) begin
                chk("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e[DW-1:0]);
                    chk("out_port", out_port, e[DW+1:DW]);
                    mlast = int'(e[DW+1:DW]);
                    mcnt[mlast] = (mcnt[mlast] + 1) % (1 << CW);
                    log_port.push_back(mlast);
                    log_cyc.push_back(cyc);
                end
            end
            p_valid = out_valid;
            p_acc = acc;
            p_data = out_data;
            p_port = out_port;
        end
        for (int i = 0; i < 3; i++) begin
            if (rd[i] && fsize(i) > 0) begin
                fpop(i, v);
                case (i)
                    0:       q0 = v;
                    1:       q1 = v;
                    default: q2 = v;
                endcase
            end
        end
        empty = {fsize(2) == 0, fsize(1) == 0, fsize(0) == 0};
        p_idle = !busy && !reset;
        p_en = enable;
        p_empty = empty;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [DW-1:0] d;
        logic [1:0] p;
        reset = 1'b1;
        enable = 1'b0;
        out_ready = 1'b0;
        empty = 3'b111;
        q0 = '0; q1 = '0; q2 = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("init_busy", busy, 0);
        chk("init_valid", out_valid, 0);
        chk("init_cnt1", cnt1, 0);

        // Single port: only queue 1 holds 0x2A.
        enable = 1'b1;
        out_ready = 1'b1;
        fpush(1, 8'h2A);
        n = 0;
        while (rd == 3'b000 && n < 10) begin tick(1); n++; end
        chk("single_rd", rd, 3'b010);
        tick(1);
        chk("single_rd_drop", rd, 3'b000);
        chk("single_valid_early", out_valid, 0);
        tick(1);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'h2A);
        chk("single_port", out_port, 1);
        tick(1);
        chk("single_accepted", out_valid, 0);
        chk("single_cnt1", cnt1, 1);

        // Round robin from reset: six words, one every four cycles.
        enable = 1'b0;
        reset_pulse();
        for (int i = 0; i < 3; i++) begin
            fpush(i, 8'(8'h10 + i));
            fpush(i, 8'(8'h20 + i));
        end
        tick(2);
        log_port.delete();
        log_cyc.delete();
        enable = 1'b1;
        n = 0;
        while (log_port.size() < 6 && n < 60) begin tick(1); n++; end
        chk("rr_words", log_port.size(), 6);
        if (log_port.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk("rr_port", log_port[i], i % 3);
            for (int i = 1; i < 6; i++) chk("rr_period", log_cyc[i] - log_cyc[i-1], 4);
        end
        tick(1);
        chk("rr_cnt0", cnt0, 2);
        chk("rr_cnt1", cnt1, 2);
        chk("rr_cnt2", cnt2, 2);

        // Backpressure: consumer stalls for ten cycles in HOLD.
        out_ready = 1'b0;
        fpush(0, 8'hC3);
        n = 0;
        while (!out_valid && n < 10) begin tick(1); n++; end
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, 8'hC3);
        chk("bp_port", out_port, 0);
        d = out_data;
        p = out_port;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("bp_stable_valid", out_valid, 1);
            chk("bp_stable_data", out_data, d);
            chk("bp_stable_port", out_port, p);
            chk("bp_no_rd", rd, 0);
        end
        out_ready = 1'b1;
        tick(1);
        chk("bp_released", out_valid, 0);
        chk("bp_idle", busy, 0);
        chk("bp_cnt0", cnt0, 3);

        // Enable dropped during READ: word completes, then arbitration stalls.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fpush(i, 8'(8'h30 + i));
            fpush(i, 8'(8'h40 + i));
        end
        tick(2);
        enable = 1'b1;
        n = 0;
        while (rd == 3'b000 && n < 10) begin tick(1); n++; end
        chk("en_rd", rd, 3'b010);
        enable = 1'b0;
        n = 0;
        while (busy && n < 10) begin tick(1); n++; end
        chk("en_done", busy, 0);
        chk("en_cnt1", cnt1, 3);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("en_blocked_rd", rd, 0);
        end
        enable = 1'b1;
        n = 0;
        while (rd == 3'b000 && n < 10) begin tick(1); n++; end
        chk("en_resume_rd", rd, 3'b100);

        // Random traffic, stalls and enable gaps.
        for (int c = 0; c < 1500; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 5) == 0 && fsize(i) < 6)
                    fpush(i, 8'($urandom_range(0, 255)));
            tick(1);
        end
        enable = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while ((fsize(0) + fsize(1) + fsize(2) != 0 || busy) && n < 400) begin tick(1); n++; end
        chk("drain_idle", busy, 0);
        chk("drain_sb_empty", sb.size(), 0);

        // Counter wrap: 17 words from port 2 with a 4-bit counter.
        reset_pulse();
        for (int i = 0; i < 17; i++) fpush(2, 8'(i));
        n = 0;
        while ((fsize(2) != 0 || busy || n < 3) && n < 200) begin tick(1); n++; end
        chk("wrap_cnt2", cnt2, 1);
        chk("wrap_cnt0", cnt0, 0);

        // Asynchronous reset while a word is held in HOLD.
        out_ready = 1'b0;
        fpush(0, 8'h5A);
        n = 0;
        while (!out_valid && n < 10) begin tick(1); n++; end
        chk("hold_before_reset", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_rd", rd, 0);
        chk("areset_valid", out_valid, 0);
        chk("areset_data", out_data, 0);
        chk("areset_port", out_port, 0);
        chk("areset_cnt0", cnt0, 0);
        chk("areset_cnt1", cnt1, 0);
        chk("areset_cnt2", cnt2, 0);
        chk("areset_busy", busy, 0);
        tick(2);
        reset = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
